// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor: FSM state encoding
// and counter-width arithmetic.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } sup_state_e;

    // Bits needed to hold max_val; never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level signal,
// reset to 0.
module bit_sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies the PLL locked flag, retries the PLL reset on lock timeout and
// releases the downstream channel resets one by one once lock is stable.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_CHAN       = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int LOCK_STABLE    = 256,
    parameter int STAGGER        = 8,
    parameter int MAX_RETRY      = 3
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked_raw,
    input  logic                fault_clr,
    output logic                pll_rst,
    output logic [NUM_CHAN-1:0] chan_rst,
    output logic                locked_q,
    output logic                fault,
    output logic [7:0]          lock_loss_cnt
);

    localparam int CW = cnt_width(max_int(max_int(PLL_RST_CYCLES, LOCK_STABLE),
                                          STAGGER * NUM_CHAN) - 1);
    localparam int TW = cnt_width(LOCK_TIMEOUT - 1);
    localparam int RW = cnt_width(MAX_RETRY);

    localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(STAGGER * NUM_CHAN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic                locked_s;
    sup_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [7:0]          loss_q, loss_d;
    logic                pll_rst_q, pll_rst_d;
    logic [NUM_CHAN-1:0] chan_rst_q, chan_rst_d;
    logic                run_q, run_d;
    logic                fault_q, fault_d;
    logic                tmo_hit;
    logic                lock_lost;

    bit_sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked_raw),
        .q_o   (locked_s)
    );

    // tmo_q saturates at its terminal value, so a late chatter exit still times out.
    assign tmo_hit   = (tmo_q == TMO_LAST);
    assign lock_lost = ((state_q == RELEASE) || (state_q == RUN)) && !locked_s;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_PLL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET_PLL: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (locked_s)     state_d = STABLE;
                else if (tmo_hit) state_d = (retry_q == RETRY_MAX) ? FAULT : RESET_PLL;
            end
            STABLE: begin
                if (!locked_s)              state_d = WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = RELEASE;
                else if (tmo_hit)           state_d = (retry_q == RETRY_MAX) ? FAULT : RESET_PLL;
            end
            RELEASE: begin
                if (!locked_s)              state_d = RESET_PLL;
                else if (cnt_q == REL_LAST) state_d = RUN;
            end
            RUN:       if (!locked_s) state_d = RESET_PLL;
            FAULT:     if (fault_clr) state_d = RESET_PLL;
            default:   state_d = RESET_PLL;
        endcase

        // cnt_q times the pulse, the stable window and the stagger; it restarts on every state change.
        cnt_d = '0;
        if ((state_d == state_q) &&
            ((state_q == RESET_PLL) || (state_q == STABLE) || (state_q == RELEASE))) begin
            cnt_d = cnt_q + 1'b1;
        end

        tmo_d = tmo_q;
        if (state_d == RESET_PLL) begin
            tmo_d = '0;
        end else if (((state_q == WAIT_LOCK) || (state_q == STABLE)) && !tmo_hit) begin
            tmo_d = tmo_q + 1'b1;
        end

        retry_d = retry_q;
        if (state_d == RUN) begin
            retry_d = '0;
        end else if ((state_q == FAULT) && fault_clr) begin
            retry_d = '0;
        end else if (lock_lost) begin
            retry_d = '0;
        end else if (((state_q == WAIT_LOCK) || (state_q == STABLE)) &&
                     (state_d == RESET_PLL)) begin
            retry_d = retry_q + 1'b1;
        end

        loss_d = loss_q;
        if (lock_lost && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end
    end

    // Outputs are decoded from the next state so every output register agrees with state_q.
    always_comb begin
        pll_rst_d  = (state_d == RESET_PLL) || (state_d == FAULT);
        fault_d    = (state_d == FAULT);
        run_d      = (state_d == RUN);
        chan_rst_d = '1;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if ((state_d == RUN) ||
                ((state_d == RELEASE) && (int'(cnt_d) >= STAGGER * (i + 1)))) begin
                chan_rst_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            tmo_q      <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            pll_rst_q  <= 1'b1;
            chan_rst_q <= '1;
            run_q      <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            pll_rst_q  <= pll_rst_d;
            chan_rst_q <= chan_rst_d;
            run_q      <= run_d;
            fault_q    <= fault_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign chan_rst      = chan_rst_q;
    assign locked_q      = run_q;
    assign fault         = fault_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters; all
// expected values are hand-derived edge counts relative to state entries.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst;
    logic       pll_locked_raw;
    logic       fault_clr;
    logic       pll_rst;
    logic [3:0] chan_rst;
    logic       locked_q;
    logic       fault;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .NUM_CHAN       (4),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (64),
        .LOCK_STABLE    (16),
        .STAGGER        (4),
        .MAX_RETRY      (2)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked_raw (pll_locked_raw),
        .fault_clr      (fault_clr),
        .pll_rst        (pll_rst),
        .chan_rst       (chan_rst),
        .locked_q       (locked_q),
        .fault          (fault),
        .lock_loss_cnt  (lock_loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance n active edges; inputs are driven and outputs sampled 1ns after each edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic raw, input logic clr);
        pll_locked_raw = raw;
        fault_clr      = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic pr, input logic [3:0] cr,
                            input logic lq, input logic ft);
        checkOutput({tag, ".pll_rst"},  32'(pll_rst),  32'(pr));
        checkOutput({tag, ".chan_rst"}, 32'(chan_rst), 32'(cr));
        checkOutput({tag, ".locked_q"}, 32'(locked_q), 32'(lq));
        checkOutput({tag, ".fault"},    32'(fault),    32'(ft));
    endtask

    initial begin
        int highs;
        int falls;
        int bad;
        logic prev;

        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #1 rst = 1'b1;
        tick(2);
        checkAll("reset", 1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("reset.loss", 32'(lock_loss_cnt), 32'd0);
        rst = 1'b0;

        // Timeout path from a fresh reset: pulses at edges 1-3 (plus reset), 68-71, 136-139.
        highs = 0;
        falls = 0;
        prev  = 1'b1;
        for (int e = 1; e <= 203; e++) begin
            tick(1);
            if (pll_rst) highs++;
            if (prev && !pll_rst) falls++;
            prev = pll_rst;
            if (e == 3)   checkOutput("tmo.e3.pll_rst", 32'(pll_rst), 32'd1);
            if (e == 4)   checkOutput("tmo.e4.pll_rst", 32'(pll_rst), 32'd0);
            if (e == 67)  checkOutput("tmo.e67.pll_rst", 32'(pll_rst), 32'd0);
            if (e == 68)  checkOutput("tmo.e68.pll_rst", 32'(pll_rst), 32'd1);
            if (e == 203) checkOutput("tmo.e203.fault", 32'(fault), 32'd0);
        end
        checkOutput("tmo.high_cycles", 32'(highs), 32'd11);
        checkOutput("tmo.falls", 32'(falls), 32'd3);
        tick(1);
        checkAll("fault.entry", 1'b1, 4'hF, 1'b0, 1'b1);
        bad = 0;
        for (int c = 0; c < 500; c++) begin
            tick(1);
            if (!(pll_rst === 1'b1 && chan_rst === 4'hF && fault === 1'b1 && locked_q === 1'b0))
                bad++;
        end
        checkOutput("fault.hold_bad_cycles", 32'(bad), 32'd0);

        // Fault clear, then a clean lock with raw rising 10 cycles after pll_rst falls.
        applyStimulus(1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0);
        checkAll("clr.next", 1'b1, 4'hF, 1'b0, 1'b0);
        tick(3);
        checkOutput("clr.pulse_end", 32'(pll_rst), 32'd1);
        tick(1);
        checkOutput("clr.pulse_fall", 32'(pll_rst), 32'd0);
        tick(10);
        applyStimulus(1'b1, 1'b0);
        tick(22);
        checkAll("clean.pre_rel", 1'b0, 4'hF, 1'b0, 1'b0);
        tick(1);
        checkOutput("clean.ch0", 32'(chan_rst), 32'hE);
        tick(4);
        checkOutput("clean.ch1", 32'(chan_rst), 32'hC);
        tick(4);
        checkAll("clean.ch2", 1'b0, 4'h8, 1'b0, 1'b0);
        tick(3);
        checkAll("clean.pre_run", 1'b0, 4'h8, 1'b0, 1'b0);
        tick(1);
        checkAll("clean.run", 1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("clean.loss", 32'(lock_loss_cnt), 32'd0);

        // fault_clr outside FAULT has no effect.
        applyStimulus(1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b0);
        tick(2);
        checkAll("run.clr_ignored", 1'b0, 4'h0, 1'b1, 1'b0);

        // Loss in RUN reaches the outputs on the third edge after the drop.
        applyStimulus(1'b0, 1'b0);
        tick(2);
        checkAll("loss.e2", 1'b0, 4'h0, 1'b1, 1'b0);
        tick(1);
        checkAll("loss.e3", 1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("loss.cnt1", 32'(lock_loss_cnt), 32'd1);
        tick(4);
        checkOutput("loss.pulse_fall", 32'(pll_rst), 32'd0);

        // Chatter: high 10, low 3, high again; release is timed from the second rise.
        tick(10);
        applyStimulus(1'b1, 1'b0);
        tick(10);
        applyStimulus(1'b0, 1'b0);
        tick(3);
        applyStimulus(1'b1, 1'b0);
        tick(11);
        checkOutput("chatter.no_early_rel", 32'(chan_rst), 32'hF);
        tick(7);
        checkOutput("chatter.pre_rel", 32'(chan_rst), 32'hF);
        tick(5);
        checkOutput("chatter.ch0", 32'(chan_rst), 32'hE);
        tick(12);
        checkAll("chatter.run", 1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("chatter.loss", 32'(lock_loss_cnt), 32'd1);

        // Late rise: STABLE is entered but the 64-cycle timeout still fires.
        applyStimulus(1'b0, 1'b0);
        tick(3);
        checkOutput("late.loss2", 32'(lock_loss_cnt), 32'd2);
        tick(4);
        checkOutput("late.wait", 32'(pll_rst), 32'd0);
        tick(50);
        applyStimulus(1'b1, 1'b0);
        tick(13);
        checkAll("late.e63", 1'b0, 4'hF, 1'b0, 1'b0);
        tick(1);
        checkAll("late.e64", 1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("late.loss_unchanged", 32'(lock_loss_cnt), 32'd2);

        // Repeated relock/loss cycles of 43 edges each, one loss per iteration.
        for (int k = 1; k <= 260; k++) begin
            applyStimulus(1'b1, 1'b0);
            tick(40);
            applyStimulus(1'b0, 1'b0);
            tick(3);
            if (k == 10)  checkOutput("sat.cnt12", 32'(lock_loss_cnt), 32'd12);
            if (k == 254) checkOutput("sat.cnt256_losses", 32'(lock_loss_cnt), 32'd255);
        end
        checkOutput("sat.cnt_held", 32'(lock_loss_cnt), 32'd255);

        // Async reset in the middle of the staggered release.
        applyStimulus(1'b1, 1'b0);
        tick(30);
        checkOutput("arst.pre_chan", 32'(chan_rst), 32'hC);
        #2 rst = 1'b1;
        #1;
        checkAll("arst.no_edge", 1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("arst.loss_cleared", 32'(lock_loss_cnt), 32'd0);
        #1 rst = 1'b0;
        tick(3);
        checkOutput("arst.pulse_end", 32'(pll_rst), 32'd1);
        tick(1);
        checkOutput("arst.pulse_fall", 32'(pll_rst), 32'd0);
        tick(20);
        checkOutput("arst.pre_rel", 32'(chan_rst), 32'hF);
        tick(1);
        checkOutput("arst.ch0", 32'(chan_rst), 32'hE);
        tick(12);
        checkAll("arst.run", 1'b0, 4'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
